mem_slot_scheduler: RTL and testbench

- Sequences the shared SDRAM system port between the ROM loader, the NES CPU and the NES PPU.
- Replaces ad-hoc download muxing with one registered scheduler. It runs in the NES clock domain and issues at most one command per NES cycle, on the `ce` strobe.
- Owns the machine-hold-in-reset policy across power-up, download and post-download drain.

---
 rtl/mem_slot_scheduler_if.sv | 44 ++++
 rtl/mem_slot_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_mem_slot_scheduler.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_slot_scheduler_if.sv
// mem_slot_scheduler_if
// Bundles the scheduler's strobes, loader path, NES request path and SDRAM
// command outputs. Signal prefixes are relative to the scheduler:
// i_* are driven into the scheduler, o_* are driven by it.
//   slave  : the scheduler itself
//   master : whatever drives the requests and observes the SDRAM side
interface mem_slot_scheduler_if #(
   parameter int ADDR_W = 22
);
   logic              i_ce;
   logic              i_downloading;
   logic              i_ldr_wr;
   logic [ADDR_W-1:0] i_ldr_addr;
   logic [7:0]        i_ldr_data;
   logic              o_ldr_full;
   logic              i_cpu_rd;
   logic              i_cpu_wr;
   logic              i_ppu_rd;
   logic [ADDR_W-1:0] i_cpu_addr;
   logic [7:0]        i_cpu_dout;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [7:0]        o_mem_din;
   logic              o_mem_we;
   logic              o_mem_oe_cpu;
   logic              o_mem_oe_ppu;
   logic              o_hold_reset;
   logic              o_load_done;
   logic [ADDR_W-1:0] o_load_count;
   logic [7:0]        o_drop_count;

   modport slave (
      input  i_ce, i_downloading, i_ldr_wr, i_ldr_addr, i_ldr_data,
             i_cpu_rd, i_cpu_wr, i_ppu_rd, i_cpu_addr, i_cpu_dout,
      output o_ldr_full, o_mem_addr, o_mem_din, o_mem_we, o_mem_oe_cpu,
             o_mem_oe_ppu, o_hold_reset, o_load_done, o_load_count, o_drop_count
   );

   modport master (
      output i_ce, i_downloading, i_ldr_wr, i_ldr_addr, i_ldr_data,
             i_cpu_rd, i_cpu_wr, i_ppu_rd, i_cpu_addr, i_cpu_dout,
      input  o_ldr_full, o_mem_addr, o_mem_din, o_mem_we, o_mem_oe_cpu,
             o_mem_oe_ppu, o_hold_reset, o_load_done, o_load_count, o_drop_count
   );
endinterface

// File: rtl/mem_slot_scheduler.sv
// mem_slot_scheduler
// Single registered arbiter for the shared SDRAM port: ROM loader writes
// (buffered in a small FIFO), NES CPU reads/writes and PPU reads. One command
// launches per NES cycle on i_ce and the mem outputs hold until the next i_ce.
// Also owns the NES hold-in-reset policy across boot, download and drain.
// Ports:
//   i_clk   : NES system clock
//   i_reset : asynchronous, active-high
//   bus     : mem_slot_scheduler_if slave (loader, NES requests, SDRAM command,
//             hold_reset / load_done / load_count / drop_count status)
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | power-up, NES held in reset, no commands, waits for a download
// LOAD  | download active, loader FIFO drained one entry per i_ce
// DRAIN | download ended, remaining FIFO entries still being written
// RUN   | NES released, CPU/PPU requests forwarded to SDRAM
module mem_slot_scheduler #(
   parameter int ADDR_W     = 22,
   parameter int FIFO_DEPTH = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   mem_slot_scheduler_if.slave bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
   localparam logic [ADDR_W-1:0] LCNT_ONE = ADDR_W'(1);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   state_t            r_state, w_state_nxt;
   logic              r_dl;
   logic              w_dl_rise, w_dl_fall;
   logic              w_load_done_nxt, w_clr_counts;

   logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
   logic [7:0]        r_fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_empty, w_full, w_feeding, w_pop, w_push, w_drop;

   logic [ADDR_W-1:0] r_mem_addr;
   logic [7:0]        r_mem_din;
   logic              r_mem_we, r_oe_cpu, r_oe_ppu;
   logic              r_load_done;
   logic [ADDR_W-1:0] r_load_count;
   logic [7:0]        r_drop_count;

   assign w_dl_rise = bus.i_downloading & ~r_dl;
   assign w_dl_fall = ~bus.i_downloading & r_dl;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_FULL);
   assign w_feeding = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
   assign w_pop     = bus.i_ce & w_feeding & ~w_empty;
   // A write arriving while full still fits if the head leaves this cycle.
   assign w_push    = bus.i_ldr_wr & (r_state != ST_RUN) & (~w_full | w_pop);
   assign w_drop    = bus.i_ldr_wr & ~w_push;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_BOOT;
         r_dl        <= 1'b0;
         r_load_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_dl        <= bus.i_downloading;
         r_load_done <= w_load_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_load_done_nxt = 1'b0;
      w_clr_counts    = 1'b0;
      case (r_state)
         ST_BOOT: begin
            if (bus.i_downloading) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            if (w_dl_fall) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            // A restarted download wins over finishing the drain.
            if (w_dl_rise) begin
               w_state_nxt = ST_LOAD;
            end else if (bus.i_ce && w_empty) begin
               w_state_nxt     = ST_RUN;
               w_load_done_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_dl_rise) begin
               w_state_nxt  = ST_LOAD;
               w_clr_counts = 1'b1;
            end
         end
         default: w_state_nxt = ST_BOOT;
      endcase
   end

   // Storage carries no reset; validity is tracked by the pointers and count.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= bus.i_ldr_addr;
         r_fifo_data[r_wr_ptr] <= bus.i_ldr_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_mem_addr <= '0;
         r_mem_din  <= '0;
         r_mem_we   <= 1'b0;
         r_oe_cpu   <= 1'b0;
         r_oe_ppu   <= 1'b0;
      end else if (bus.i_ce) begin
         if (w_pop) begin
            r_mem_addr <= r_fifo_addr[r_rd_ptr];
            r_mem_din  <= r_fifo_data[r_rd_ptr];
            r_mem_we   <= 1'b1;
            r_oe_cpu   <= 1'b0;
            r_oe_ppu   <= 1'b0;
         end else if (r_state == ST_RUN) begin
            // Core should never overlap strobes; if it does, write wins, then CPU read.
            r_mem_addr <= bus.i_cpu_addr;
            r_mem_din  <= bus.i_cpu_dout;
            r_mem_we   <= bus.i_cpu_wr;
            r_oe_cpu   <= bus.i_cpu_rd & ~bus.i_cpu_wr;
            r_oe_ppu   <= bus.i_ppu_rd & ~bus.i_cpu_rd & ~bus.i_cpu_wr;
         end else begin
            r_mem_we   <= 1'b0;
            r_oe_cpu   <= 1'b0;
            r_oe_ppu   <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_load_count <= '0;
         r_drop_count <= '0;
      end else if (w_clr_counts) begin
         r_load_count <= '0;
         r_drop_count <= '0;
      end else begin
         if (w_pop) r_load_count <= r_load_count + LCNT_ONE;
         if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
      end
   end

   assign bus.o_ldr_full   = w_full;
   assign bus.o_mem_addr   = r_mem_addr;
   assign bus.o_mem_din    = r_mem_din;
   assign bus.o_mem_we     = r_mem_we;
   assign bus.o_mem_oe_cpu = r_oe_cpu;
   assign bus.o_mem_oe_ppu = r_oe_ppu;
   assign bus.o_hold_reset = (r_state != ST_RUN);
   assign bus.o_load_done  = r_load_done;
   assign bus.o_load_count = r_load_count;
   assign bus.o_drop_count = r_drop_count;
endmodule

// File: tb/tb_mem_slot_scheduler.sv
module tb_mem_slot_scheduler;
   localparam int AW    = 22;
   localparam int DEPTH = 4;
   localparam int M_BOOT = 0, M_LOAD = 1, M_DRAIN = 2, M_RUN = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_slot_scheduler_if #(.ADDR_W(AW)) bus ();
   mem_slot_scheduler #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_done_seen = 0;
   bit ce_en = 1'b1;

   // Reference model: loader queue, mode, and the expected registered outputs.
   typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } ent_t;
   ent_t          mq[$];
   int            m_mode;
   logic          m_dl;
   logic [AW-1:0] m_addr;
   logic [7:0]    m_din;
   logic          m_we, m_oec, m_oep, m_done;
   logic [AW-1:0] m_lcnt;
   int            m_dcnt;
   bit            mr_rise, mr_fall, mr_was_empty;
   ent_t          mr_e;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_mode = M_BOOT; m_dl = 1'b0;
         m_addr = '0; m_din = '0; m_we = 0; m_oec = 0; m_oep = 0; m_done = 0;
         m_lcnt = '0; m_dcnt = 0;
      end else begin
         mr_rise      = bus.i_downloading && !m_dl;
         mr_fall      = !bus.i_downloading && m_dl;
         mr_was_empty = (mq.size() == 0);
         m_done       = 1'b0;
         if (bus.i_ce) begin
            if ((m_mode == M_LOAD || m_mode == M_DRAIN) && !mr_was_empty) begin
               mr_e = mq.pop_front();
               m_addr = mr_e.a; m_din = mr_e.d; m_we = 1; m_oec = 0; m_oep = 0;
               m_lcnt = m_lcnt + 1'b1;
            end else if (m_mode == M_RUN) begin
               m_addr = bus.i_cpu_addr; m_din = bus.i_cpu_dout;
               m_we = 0; m_oec = 0; m_oep = 0;
               if (bus.i_cpu_wr)      m_we  = 1;
               else if (bus.i_cpu_rd) m_oec = 1;
               else if (bus.i_ppu_rd) m_oep = 1;
            end else begin
               m_we = 0; m_oec = 0; m_oep = 0;
            end
         end
         if (bus.i_ldr_wr) begin
            if (m_mode != M_RUN && mq.size() < DEPTH) begin
               mr_e.a = bus.i_ldr_addr; mr_e.d = bus.i_ldr_data;
               mq.push_back(mr_e);
            end else if (m_dcnt < 255) begin
               m_dcnt++;
            end
         end
         case (m_mode)
            M_BOOT:  if (bus.i_downloading) m_mode = M_LOAD;
            M_LOAD:  if (mr_fall) m_mode = M_DRAIN;
            M_DRAIN: if (mr_rise) m_mode = M_LOAD;
                     else if (bus.i_ce && mr_was_empty) begin m_mode = M_RUN; m_done = 1; end
            default: if (mr_rise) begin m_mode = M_LOAD; m_lcnt = '0; m_dcnt = 0; end
         endcase
         m_dl = bus.i_downloading;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("mem_addr",   32'(bus.o_mem_addr),   32'(m_addr));
      chk("mem_din",    32'(bus.o_mem_din),    32'(m_din));
      chk("mem_we",     32'(bus.o_mem_we),     32'(m_we));
      chk("mem_oe_cpu", 32'(bus.o_mem_oe_cpu), 32'(m_oec));
      chk("mem_oe_ppu", 32'(bus.o_mem_oe_ppu), 32'(m_oep));
      chk("hold_reset", 32'(bus.o_hold_reset), 32'(m_mode != M_RUN));
      chk("load_done",  32'(bus.o_load_done),  32'(m_done));
      chk("load_count", 32'(bus.o_load_count), 32'(m_lcnt));
      chk("drop_count", 32'(bus.o_drop_count), 32'(m_dcnt));
      chk("ldr_full",   32'(bus.o_ldr_full),   32'(mq.size() == DEPTH));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_hold"},  32'(bus.o_hold_reset), 32'd1);
      chk({tag, "_we"},    32'(bus.o_mem_we),     32'd0);
      chk({tag, "_oec"},   32'(bus.o_mem_oe_cpu), 32'd0);
      chk({tag, "_oep"},   32'(bus.o_mem_oe_ppu), 32'd0);
      chk({tag, "_addr"},  32'(bus.o_mem_addr),   32'd0);
      chk({tag, "_din"},   32'(bus.o_mem_din),    32'd0);
      chk({tag, "_done"},  32'(bus.o_load_done),  32'd0);
      chk({tag, "_lcnt"},  32'(bus.o_load_count), 32'd0);
      chk({tag, "_dcnt"},  32'(bus.o_drop_count), 32'd0);
      chk({tag, "_full"},  32'(bus.o_ldr_full),   32'd0);
   endtask

   // One clock: sample after the edge, check, then set up strobes for the next edge.
   task automatic cycle();
      @(posedge clk);
      #1;
      check_model();
      if (bus.o_load_done) n_done_seen++;
      cyc++;
      bus.i_ce     = ce_en && (cyc % 4 == 0);
      bus.i_ldr_wr = 1'b0;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [7:0] d);
      bus.i_ldr_wr = 1'b1; bus.i_ldr_addr = a; bus.i_ldr_data = d;
      cycle();
   endtask

   task automatic rand_cpu();
      bus.i_cpu_addr = AW'($urandom);
      bus.i_cpu_dout = 8'($urandom);
      bus.i_cpu_rd   = 1'($urandom_range(0, 1));
      bus.i_cpu_wr   = 1'($urandom_range(0, 1));
      bus.i_ppu_rd   = 1'($urandom_range(0, 1));
   endtask

   initial begin
      int k;
      int done_base;
      bus.i_ce = 0; bus.i_downloading = 0; bus.i_ldr_wr = 0;
      bus.i_ldr_addr = '0; bus.i_ldr_data = '0;
      bus.i_cpu_rd = 0; bus.i_cpu_wr = 0; bus.i_ppu_rd = 0;
      bus.i_cpu_addr = '0; bus.i_cpu_dout = '0;
      reset = 1'b0;
      #2 reset = 1'b1;
      #20;
      check_reset_values("rst");
      @(negedge clk) reset = 1'b0;

      // BOOT: 100 NES cycles with random (ignored) NES traffic.
      repeat (400) begin rand_cpu(); cycle(); end
      chk("boot_hold", 32'(bus.o_hold_reset), 32'd1);
      chk("boot_we",   32'(bus.o_mem_we),     32'd0);
      bus.i_cpu_rd = 0; bus.i_cpu_wr = 0; bus.i_ppu_rd = 0;

      // Start download; three paced writes.
      bus.i_downloading = 1'b1;
      cycle();
      for (int i = 0; i < 3; i++) begin
         push(AW'(32'h10 + i), 8'(8'hA1 + i));
         repeat (3) cycle();
      end
      repeat (8) cycle();
      chk("load_count_3", 32'(bus.o_load_count), 32'd3);

      // Burst of six with no ce: four fit, two dropped.
      ce_en = 1'b0; bus.i_ce = 1'b0;
      for (int i = 0; i < 6; i++) begin
         push(AW'(32'h100 + i), 8'($urandom));
         if (i == 3) chk("full_after_4", 32'(bus.o_ldr_full), 32'd1);
      end
      chk("drop_count_2", 32'(bus.o_drop_count), 32'd2);
      ce_en = 1'b1;
      repeat (20) cycle();
      chk("load_count_7", 32'(bus.o_load_count), 32'd7);
      chk("full_cleared", 32'(bus.o_ldr_full),   32'd0);

      // Random loader traffic during LOAD.
      repeat (200) begin
         bus.i_ldr_wr   = ($urandom_range(0, 2) == 0);
         bus.i_ldr_addr = AW'($urandom);
         bus.i_ldr_data = 8'($urandom);
         rand_cpu();
         cycle();
      end
      bus.i_cpu_rd = 0; bus.i_cpu_wr = 0; bus.i_ppu_rd = 0;
      repeat (24) cycle();

      // Abort during DRAIN: a restart goes back to LOAD with no load_done.
      done_base = n_done_seen;
      ce_en = 1'b0; bus.i_ce = 1'b0;
      for (int i = 0; i < 3; i++) push(AW'(32'h200 + i), 8'($urandom));
      bus.i_downloading = 1'b0;
      cycle();
      ce_en = 1'b1;
      k = 0;
      while (mq.size() != 2 && k < 20) begin cycle(); k++; end
      chk("abort_one_popped", 32'(k < 20), 32'd1);
      bus.i_downloading = 1'b1;
      cycle();
      repeat (24) cycle();
      chk("abort_no_done", 32'(n_done_seen - done_base), 32'd0);
      chk("abort_hold",    32'(bus.o_hold_reset),       32'd1);

      // Normal end of download with two entries queued.
      done_base = n_done_seen;
      ce_en = 1'b0; bus.i_ce = 1'b0;
      push(AW'(32'h300), 8'h5A);
      push(AW'(32'h301), 8'hC3);
      bus.i_downloading = 1'b0;
      cycle();
      ce_en = 1'b1;
      k = 0;
      while (!bus.o_load_done && k < 40) begin cycle(); k++; end
      chk("drain_done_pulse", 32'(bus.o_load_done),  32'd1);
      chk("drain_hold_fall",  32'(bus.o_hold_reset), 32'd0);
      repeat (12) cycle();
      chk("drain_done_once", 32'(n_done_seen - done_base), 32'd1);

      // RUN: single CPU read, then all strobes together.
      bus.i_cpu_addr = AW'(32'h8000); bus.i_cpu_dout = 8'h77;
      bus.i_cpu_rd = 1; bus.i_cpu_wr = 0; bus.i_ppu_rd = 0;
      repeat (4) cycle();
      chk("run_rd_oe",   32'(bus.o_mem_oe_cpu), 32'd1);
      chk("run_rd_addr", 32'(bus.o_mem_addr),   32'h8000);
      chk("run_rd_we",   32'(bus.o_mem_we),     32'd0);
      bus.i_cpu_rd = 1; bus.i_cpu_wr = 1; bus.i_ppu_rd = 1;
      repeat (4) cycle();
      chk("run_all_we",  32'(bus.o_mem_we),     32'd1);
      chk("run_all_oec", 32'(bus.o_mem_oe_cpu), 32'd0);
      chk("run_all_oep", 32'(bus.o_mem_oe_ppu), 32'd0);

      // Random NES traffic with stray loader writes.
      repeat (300) begin
         rand_cpu();
         bus.i_ldr_wr = ($urandom_range(0, 3) == 0);
         cycle();
      end
      repeat (300) begin bus.i_ldr_wr = 1'b1; cycle(); end
      chk("drop_saturated", 32'(bus.o_drop_count), 32'd255);
      bus.i_cpu_rd = 0; bus.i_cpu_wr = 0; bus.i_ppu_rd = 0;

      // New download from RUN clears the counters.
      bus.i_downloading = 1'b1;
      cycle();
      chk("reload_lcnt", 32'(bus.o_load_count), 32'd0);
      chk("reload_dcnt", 32'(bus.o_drop_count), 32'd0);
      chk("reload_hold", 32'(bus.o_hold_reset), 32'd1);
      repeat (8) cycle();

      // Asynchronous reset with three entries queued.
      ce_en = 1'b0; bus.i_ce = 1'b0;
      for (int i = 0; i < 3; i++) push(AW'(32'h400 + i), 8'($urandom));
      #2 reset = 1'b1;
      bus.i_downloading = 1'b0;
      #1;
      check_reset_values("mid_rst");
      @(negedge clk) reset = 1'b0;
      ce_en = 1'b1;
      repeat (40) begin
         cycle();
         chk("post_rst_no_we", 32'(bus.o_mem_we), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
